// File: rtl/irq_injector_pkg.sv
`default_nettype none
// ============================================================================
// irq_inj_pkg : shared state encoding and word-aligned address compare
// Revision    : 1.0
// ============================================================================
package irq_inj_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ASSERT = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  function automatic logic addr_match(input logic [31:0] a, input logic [31:0] b);
    return (a & WORD_MASK) == (b & WORD_MASK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_injector.sv
`default_nettype none
// ============================================================================
// irq_injector : PC-triggered external interrupt source with ack and watchdog
// Revision     : 1.0
// ============================================================================
module irq_injector
  import irq_inj_pkg::*;
#(
  parameter logic [31:0] TRIGGER_PC = 32'h0000_3018,
  parameter logic [31:0] ACK_ADDR   = 32'h0000_7F20,
  parameter int unsigned DELAY      = 0,
  parameter int unsigned MAX_COUNT  = 1,
  parameter int unsigned HOLD_MAX   = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] macroscopic_pc,
  input  logic [31:0] m_data_addr,
  input  logic [3:0]  m_data_byteen,
  output logic        interrupt,
  output logic [7:0]  irq_count,
  output logic        timeout,
  output logic [1:0]  state
);

  localparam logic [7:0]  DELAY_L   = 8'(DELAY);
  localparam logic [7:0]  MAX_L     = 8'(MAX_COUNT);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

  state_e      state_q;
  logic        interrupt_q;
  logic [7:0]  irq_count_q;
  logic        timeout_q;
  logic        pc_left_q;
  logic [7:0]  dcnt_q;
  logic [15:0] hold_q;

  logic w_trig;
  logic w_ack;

  assign w_trig = addr_match(macroscopic_pc, TRIGGER_PC);
  assign w_ack  = (|m_data_byteen) && addr_match(m_data_addr, ACK_ADDR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      interrupt_q <= 1'b0;
      irq_count_q <= 8'd0;
      timeout_q   <= 1'b0;
      pc_left_q   <= 1'b1;
      dcnt_q      <= 8'd0;
      hold_q      <= 16'd0;
    end else begin
      // Re-arming requires the PC to have moved off the trigger at least once.
      if (!w_trig) begin
        pc_left_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (enable && w_trig && pc_left_q && (irq_count_q < MAX_L)) begin
            pc_left_q <= 1'b0;
            if (DELAY_L == 8'd0) begin
              state_q     <= ST_ASSERT;
              interrupt_q <= 1'b1;
              irq_count_q <= irq_count_q + 8'd1;
              hold_q      <= 16'd0;
            end else begin
              state_q <= ST_WAIT;
              dcnt_q  <= DELAY_L;
            end
          end
        end
        ST_WAIT: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            dcnt_q  <= 8'd0;
          end else if (dcnt_q == 8'd1) begin
            state_q     <= ST_ASSERT;
            dcnt_q      <= 8'd0;
            interrupt_q <= 1'b1;
            irq_count_q <= irq_count_q + 8'd1;
            hold_q      <= 16'd0;
          end else begin
            dcnt_q <= dcnt_q - 8'd1;
          end
        end
        ST_ASSERT: begin
          // Ack takes priority over watchdog expiry in the same cycle.
          if (w_ack) begin
            state_q     <= ST_DONE;
            interrupt_q <= 1'b0;
          end else if (hold_q == HOLD_LAST) begin
            state_q     <= ST_DONE;
            interrupt_q <= 1'b0;
            timeout_q   <= 1'b1;
          end else begin
            hold_q <= hold_q + 16'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign interrupt = interrupt_q;
  assign irq_count = irq_count_q;
  assign timeout   = timeout_q;
  assign state     = state_q;

endmodule
`default_nettype wire
